// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at the tail on dispatch, marks entries complete
// from the CDB, retires in program order from the head, and flushes on squash.
package rob_pkg;
  localparam int ROB_SZ_DEF = 8;
  localparam int ROB_TAG_W  = $clog2(ROB_SZ_DEF + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest_reg;
    logic [31:0] inst;
  } ID_EX_PACKET;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          value;
  } CDB_PACKET;

  typedef struct packed {
    logic                 valid;
    logic                 complete;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          value;
    ID_EX_PACKET          id_packet;
  } ROB_ENTRY;
endpackage

module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_SZ = rob_pkg::ROB_SZ_DEF,
  parameter int TAG_W  = $clog2(ROB_SZ + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      dispatch_valid,
  input  ID_EX_PACKET               id_packet,
  input  CDB_PACKET                 cdb_packet,
  input  logic                      retire_stall,
  input  logic                      squash,
  output ROB_ENTRY                  rob_tail_packet,
  output ROB_ENTRY                  rob_head_packet,
  output logic                      retire_valid,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(ROB_SZ):0]   count
);
  localparam int PTR_W = $clog2(ROB_SZ);
  localparam int CNT_W = $clog2(ROB_SZ) + 1;

  logic [ROB_SZ-1:0] valid_q, valid_d;
  logic [ROB_SZ-1:0] complete_q, complete_d;
  logic [31:0]       value_q [ROB_SZ];
  logic [31:0]       value_d [ROB_SZ];
  ID_EX_PACKET       pkt_q [ROB_SZ];
  ID_EX_PACKET       pkt_d [ROB_SZ];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              alloc;
  logic [TAG_W-1:0]  cdb_tag;
  logic [PTR_W-1:0]  cdb_idx;
  logic              cdb_hit;

  assign full    = (count_q == CNT_W'(ROB_SZ));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign alloc   = dispatch_valid && !full;
  assign cdb_tag = TAG_W'(cdb_packet.rob_tag);
  assign cdb_idx = PTR_W'(cdb_tag - TAG_W'(1));
  assign cdb_hit = (cdb_tag != '0) && (cdb_tag <= TAG_W'(ROB_SZ)) && valid_q[cdb_idx];

  assign retire_valid = valid_q[head_q] && complete_q[head_q] && !retire_stall;

  always_comb begin
    rob_tail_packet           = '0;
    rob_tail_packet.valid     = alloc;
    rob_tail_packet.rob_tag   = ROB_TAG_W'(TAG_W'(tail_q) + TAG_W'(1));
    rob_tail_packet.id_packet = id_packet;

    rob_head_packet           = '0;
    rob_head_packet.valid     = valid_q[head_q];
    rob_head_packet.complete  = complete_q[head_q];
    rob_head_packet.rob_tag   = ROB_TAG_W'(TAG_W'(head_q) + TAG_W'(1));
    rob_head_packet.value     = value_q[head_q];
    rob_head_packet.id_packet = pkt_q[head_q];
  end

  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    value_d    = value_q;
    pkt_d      = pkt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    // CDB is applied before retire so a late broadcast cannot revive a retiring slot.
    if (cdb_hit) begin
      complete_d[cdb_idx] = 1'b1;
      value_d[cdb_idx]    = cdb_packet.value;
    end
    if (retire_valid) begin
      valid_d[head_q]    = 1'b0;
      complete_d[head_q] = 1'b0;
      head_d             = head_q + PTR_W'(1);
    end
    if (alloc) begin
      valid_d[tail_q]    = 1'b1;
      complete_d[tail_q] = 1'b0;
      pkt_d[tail_q]      = id_packet;
      tail_d             = tail_q + PTR_W'(1);
    end
    case ({alloc, retire_valid})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (squash) begin
      valid_d    = '0;
      complete_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < ROB_SZ; i++) begin
        value_q[i] <= '0;
        pkt_q[i]   <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      for (int i = 0; i < ROB_SZ; i++) begin
        value_q[i] <= value_d[i];
        pkt_q[i]   <= pkt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, all checked
// against an in-order queue model of the ROB kept here.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic        clock;
  logic        reset;
  logic        dispatch_valid;
  ID_EX_PACKET id_packet;
  CDB_PACKET   cdb_packet;
  logic        retire_stall;
  logic        squash;
  ROB_ENTRY    rob_tail_packet;
  ROB_ENTRY    rob_head_packet;
  logic        retire_valid;
  logic        full;
  logic        empty;
  logic [3:0]  count;

  reorder_buffer dut (
    .clock           (clock),
    .reset           (reset),
    .dispatch_valid  (dispatch_valid),
    .id_packet       (id_packet),
    .cdb_packet      (cdb_packet),
    .retire_stall    (retire_stall),
    .squash          (squash),
    .rob_tail_packet (rob_tail_packet),
    .rob_head_packet (rob_head_packet),
    .retire_valid    (retire_valid),
    .full            (full),
    .empty           (empty),
    .count           (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: program-order list of in-flight instructions.
  typedef struct {
    int          tag;
    bit          cpl;
    logic [31:0] val;
    logic [4:0]  rd;
  } m_ent_t;

  m_ent_t mq[$];
  int     next_tag = 1;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit dv, input logic [4:0] rd, input int ctag,
                      input logic [31:0] cval, input bit stall, input bit sq,
                      input bit rst_n);
    bit exp_ret;
    bit pre_full;
    int head_tag;
    dispatch_valid      = dv;
    id_packet.pc        = $urandom;
    id_packet.dest_reg  = rd;
    id_packet.inst      = $urandom;
    cdb_packet.rob_tag  = ROB_TAG_W'(ctag);
    cdb_packet.value    = cval;
    retire_stall        = stall;
    squash              = sq;
    reset               = rst_n;
    #1;
    exp_ret  = (mq.size() > 0) && mq[0].cpl && !stall;
    pre_full = (mq.size() == 8);
    head_tag = (mq.size() > 0) ? mq[0].tag : next_tag;
    if (rst_n) begin
      check_eq("retire_valid", retire_valid, exp_ret);
      check_eq("count", count, mq.size());
      check_eq("full", full, pre_full);
      check_eq("empty", empty, mq.size() == 0);
      check_eq("tail_tag", rob_tail_packet.rob_tag, next_tag);
      check_eq("tail_rd", rob_tail_packet.id_packet.dest_reg, rd);
      check_eq("head_tag", rob_head_packet.rob_tag, head_tag);
      check_eq("head_valid", rob_head_packet.valid, mq.size() > 0);
      check_eq("head_cpl", rob_head_packet.complete, (mq.size() > 0) && mq[0].cpl);
      if (mq.size() > 0) begin
        check_eq("head_rd", rob_head_packet.id_packet.dest_reg, mq[0].rd);
        if (mq[0].cpl) check_eq("head_value", rob_head_packet.value, mq[0].val);
      end
    end
    @(posedge clock);
    if (!rst_n || sq) begin
      mq.delete();
      next_tag = 1;
    end else begin
      foreach (mq[i]) begin
        if (mq[i].tag == ctag) begin
          mq[i].cpl = 1'b1;
          mq[i].val = cval;
        end
      end
      if (exp_ret) void'(mq.pop_front());
      if (dv && !pre_full) begin
        mq.push_back('{tag: next_tag, cpl: 1'b0, val: 32'h0, rd: rd});
        next_tag = (next_tag % 8) + 1;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    dispatch_valid = 0;
    id_packet      = '0;
    cdb_packet     = '0;
    retire_stall   = 0;
    squash         = 0;
    reset          = 0;

    // Reset
    do_reset();
    #1;
    check_eq("rst_empty", empty, 1);
    check_eq("rst_tail_tag", rob_tail_packet.rob_tag, 1);
    idle(1);

    // In-order retire over out-of-order completion
    step(1, 5, 0, 0, 0, 0, 1);
    step(1, 6, 0, 0, 0, 0, 1);
    step(1, 7, 0, 0, 0, 0, 1);
    check_eq("plan_count3", count, 3);
    step(0, 0, 2, 32'hAB, 0, 0, 1);
    step(0, 0, 1, 32'h11, 0, 0, 1);
    check_eq("plan_ret_tag1", {retire_valid, rob_head_packet.value}, {1'b1, 32'h11});
    step(0, 0, 0, 0, 0, 0, 1);
    check_eq("plan_ret_tag2", {retire_valid, rob_head_packet.value}, {1'b1, 32'hAB});
    idle(1);
    check_eq("plan_count1", count, 1);

    // Full and wrap
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 5'(i), 0, 0, 0, 0, 1);
    check_eq("plan_full", {full, count}, {1'b1, 4'd8});
    step(1, 9, 0, 0, 0, 0, 1);
    check_eq("plan_9th", count, 8);
    step(0, 0, 1, 32'h55, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 3, 0, 0, 0, 0, 1);
    check_eq("plan_wrap_count", count, 8);

    // Simultaneous retire + dispatch at count 4, and CDB tag 0
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 5'(i + 1), 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h1234, 0, 0, 1);
    step(1, 20, 0, 0, 0, 0, 1);
    check_eq("plan_sim_count", count, 4);
    step(0, 0, 0, 32'hDEAD, 0, 0, 1);

    // Stall
    step(0, 0, 2, 32'h77, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 1);
    check_eq("plan_stall_count", count, 4);
    step(0, 0, 0, 0, 0, 0, 1);
    check_eq("plan_unstall_count", count, 3);

    // Squash mid-operation, then stale CDB
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 5'(i), 0, 0, 0, 0, 1);
    step(1, 9, 0, 0, 0, 1, 1);
    check_eq("plan_squash", {empty, count, rob_tail_packet.rob_tag}, {1'b1, 4'd0, 4'd1});
    step(0, 0, 3, 32'hBAD, 0, 0, 1);
    idle(1);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) step(1, 5'(i), 0, 0, 0, 0, 1);
    step(1, 9, 0, 0, 0, 0, 0);
    check_eq("plan_reset_mid", {empty, count, rob_tail_packet.rob_tag}, {1'b1, 4'd0, 4'd1});
    step(0, 0, 3, 32'hBAD, 0, 0, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int ctag;
      if (mq.size() > 0 && $urandom_range(0, 2) != 0)
        ctag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        ctag = $urandom_range(0, 15);
      step($urandom_range(0, 2) != 0, 5'($urandom), ctag, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0,
           $urandom_range(0, 150) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer for the Tomasulo OoO core; it produces the tail (dispatch) and head (retire) ROB_ENTRY packets that the map table and RS consume.
- Allocates one entry per dispatch and marks entries complete from the CDB.
- Retires in program order, one per cycle, and flushes on squash.
- ROB tags are 1..ROB_SZ; tag 0 means "no tag / value in regfile".

Parameters:
- ROB_SZ, 8, number of entries; must be a power of 2.
- TAG_W, $clog2(ROB_SZ+1), width of the rob_tag field.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset asserted, sampled on posedge clock)
- dispatch_valid  in  1  RS accepted the instruction on id_packet this cycle
- id_packet  in  ID_EX_PACKET  decoded instruction being dispatched
- cdb_packet  in  CDB_PACKET  completion broadcast (rob_tag, value); rob_tag 0 = idle
- retire_stall  in  1  commit stage cannot accept a retirement this cycle
- squash  in  1  flush all entries (mispredict/exception)
- rob_tail_packet  out  ROB_ENTRY  entry being allocated: id_packet passthrough, rob_tag = tail tag
- rob_head_packet  out  ROB_ENTRY  oldest entry, including complete and value
- retire_valid  out  1  head retires at this posedge
- full  out  1  count == ROB_SZ
- empty  out  1  count == 0
- count  out  $clog2(ROB_SZ)+1  occupied entries

Behaviour:
- Storage: ROB_SZ entries (valid, complete, id_packet, value). Slot i carries tag i+1.
- State: head_ptr, tail_ptr (log2 ROB_SZ bits, wrap naturally), count.
- Reset (reset==0 at posedge):
  - all entries valid=0, complete=0, value=0; head=tail=0; count=0.
  - Outputs after reset: empty=1, full=0, count=0, retire_valid=0, rob_tail_packet.rob_tag=1, rob_head_packet.rob_tag=1 with complete=0.
  - Reset overrides every other input, including mid-operation.
- Allocate: alloc = dispatch_valid && !full.
  - rob_tail_packet is combinational: the tag is visible in the same cycle as dispatch_valid, so the map table can capture it.
  - At posedge: slot[tail] gets valid=1, complete=0, id_packet; tail+1.
  - dispatch_valid while full is ignored. No bypass from a same-cycle retire: a full ROB rejects dispatch even when retiring. Upstream stalls on full.
- Complete: at posedge, if cdb_packet.rob_tag != 0 and slot[tag-1].valid, set complete=1 and latch value.
  - A CDB tag to an invalid slot is ignored.
  - A completion is visible on rob_head_packet/retire_valid the cycle after the CDB edge; there is no same-cycle bypass.
- Retire: retire_valid = slot[head].valid && slot[head].complete && !retire_stall (combinational).
  - At posedge when retire_valid: slot[head].valid=0, complete=0; head+1.
  - Tags are not reused until the slot is retired.
- Count: +1 on alloc only, −1 on retire only, unchanged on both or neither.
- Squash (at posedge, priority below reset, above alloc/complete):
  - A same-cycle retire still commits; retire_valid is not gated by squash.
  - All valid/complete cleared; head=tail=0; count=0.
  - The same-cycle alloc and CDB write are dropped.
- Wrap: pointers roll ROB_SZ−1 → 0. Tag sequence 1..8, 1, ...
- Empty: retire_valid=0; rob_head_packet reflects the invalid slot with complete=0.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release → empty=1, full=0, count=0, retire_valid=0, rob_tail_packet.rob_tag=1.
- In-order retire over OoO completion:
  - Dispatch 3 instructions (rd 5, 6, 7) → tags 1, 2, 3; count=3.
  - CDB tag 2 value 0xAB → retire_valid stays 0.
  - CDB tag 1 value 0x11 → next cycle retire_valid=1, head tag 1 value 0x11.
  - Following cycle head tag 2 value 0xAB retires; count=1.
- Full/wrap:
  - 8 dispatches → full=1, count=8, tail tag back to 1.
  - A 9th dispatch_valid leaves count=8.
  - Complete and retire tag 1, then dispatch → new entry gets tag 1 (wrap).
- Simultaneous:
  - count=4, head complete, dispatch_valid=1 in the same cycle → count stays 4, head advances, tail advances.
  - CDB tag 0 changes nothing.
- Stall:
  - head complete, retire_stall=1 for 3 cycles → retire_valid=0, count unchanged.
  - Deassert → retires next edge.
- Squash/reset mid-op:
  - 5 entries, squash=1 with dispatch_valid=1 → next cycle count=0, empty=1, tail tag 1.
  - Stale CDB tag 3 afterwards is ignored.
  - Repeat using reset=0 instead of squash → same result.
